// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder stepped LSB-first, one bit per clock,
// with a start/busy/done handshake and registered result outputs.

module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy_out,
    output logic             done_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sr_q,      a_sr_d;
    logic [WIDTH-1:0] b_sr_q,      b_sr_d;
    logic [WIDTH-1:0] sum_sr_q,    sum_sr_d;
    logic             carry_q,     carry_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] sum_res_q,   sum_res_d;
    logic             carry_res_q, carry_res_d;

    logic fa_sum;
    logic fa_carry;

    full_adder u_fa (
        .a_in     (a_sr_q[0]),
        .b_in     (b_sr_q[0]),
        .c_in     (carry_q),
        .sum_out  (fa_sum),
        .carry_out(fa_carry)
    );

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_res_d   = sum_res_q;
        carry_res_d = carry_res_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CW'(1);
                // Results are published only once the final bit is known,
                // so the outputs never expose a partial sum.
                if (cnt_q == LAST_BIT) begin
                    sum_res_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    carry_res_d = fa_carry;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_res_q   <= '0;
            carry_res_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_res_q   <= sum_res_d;
            carry_res_q <= carry_res_d;
        end
    end

    assign sum_out   = sum_res_q;
    assign carry_out = carry_res_q;
    assign busy_out  = (state_q == RUN);
    assign done_out  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed 8-bit vectors plus an
// exhaustive 4-bit sweep on a second instance.

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] sum8;
    logic       carry8, busy8, done8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;
    logic [3:0] sum4;
    logic       carry4, busy4, done4;

    int total = 0;
    int bad   = 0;

    logic [32:0] q8[$];
    logic [32:0] q4[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start8),
        .a_in     (a8),
        .b_in     (b8),
        .c_in     (c8),
        .sum_out  (sum8),
        .carry_out(carry8),
        .busy_out (busy8),
        .done_out (done8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start4),
        .a_in     (a4),
        .b_in     (b4),
        .c_in     (c4),
        .sum_out  (sum4),
        .carry_out(carry4),
        .busy_out (busy4),
        .done_out (done4)
    );

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic flagFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected normal progress", name);
    endtask

    // Monitors pop the oldest expected result whenever a done pulse appears.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && done8) begin
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb8_spurious: got done with result %0d, expected no done", {carry8, sum8});
                end else begin
                    exp = q8.pop_front();
                    checkOutput("sb8_result", {24'd0, carry8, sum8}, exp);
                end
            end
        end
    end

    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && done4) begin
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb4_spurious: got done with result %0d, expected no done", {carry4, sum4});
                end else begin
                    exp = q4.pop_front();
                    checkOutput("sb4_result", {28'd0, carry4, sum4}, exp);
                end
            end
        end
    end

    task automatic waitIdle8();
        int n = 0;
        while ((busy8 || done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8 || done8) flagFail("idle8_timeout");
    endtask

    task automatic waitIdle4();
        int n = 0;
        while ((busy4 || done4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy4 || done4) flagFail("idle4_timeout");
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0) flagFail("drain8_timeout");
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) flagFail("drain4_timeout");
    endtask

    // Issues one op on the 8-bit DUT; returns at the negedge after the accept
    // edge with the operand inputs scrambled to prove they were latched.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input logic [32:0] exp);
        waitIdle8();
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        c8 = c;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        c8 = ~c;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCnt;
        int doneAt;

        repeat (3) @(negedge clk);
        checkOutput("reset8_outputs", {29'd0, done8, busy8, carry8, sum8 == 8'd0}, 33'd1);
        checkOutput("reset4_outputs", {27'd0, done4, busy4, carry4, sum4}, 33'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset8", {22'd0, done8, busy8, carry8, sum8}, 33'd0);

        // 3 + 5: busy for 8 cycles, done 8 edges after accept
        applyStimulus(8'd3, 8'd5, 1'b0, 33'd8);
        busyCnt = 0;
        doneAt  = -1;
        for (int j = 0; j <= 20; j++) begin
            if (busy8) busyCnt++;
            if (done8) begin
                doneAt = j;
                break;
            end
            @(negedge clk);
        end
        checkOutput("t1_busy_cycles", 33'(busyCnt), 33'd8);
        checkOutput("t1_done_latency", 33'(doneAt), 33'd8);
        @(negedge clk);
        checkOutput("t1_done_single", {31'd0, done8, busy8}, 33'd0);
        drain8();

        applyStimulus(8'd255, 8'd1, 1'b0, 33'h100);
        drain8();
        applyStimulus(8'd255, 8'd255, 1'b1, 33'h1FF);
        drain8();

        // Back-to-back with start held; operands change mid-run
        waitIdle8();
        start8 = 1'b1;
        a8 = 8'd10;
        b8 = 8'd20;
        c8 = 1'b0;
        q8.push_back(33'd30);
        @(negedge clk);
        checkOutput("t3_busy_e0", {32'd0, busy8}, 33'd1);
        repeat (3) @(negedge clk);
        a8 = 8'd1;
        b8 = 8'd1;
        q8.push_back(33'd2);
        repeat (5) @(negedge clk);
        checkOutput("t3_done_e8", {31'd0, done8, busy8}, 33'd2);
        @(negedge clk);
        checkOutput("t3_idle_e9", {31'd0, done8, busy8}, 33'd0);
        @(negedge clk);
        checkOutput("t3_accept_e10", {31'd0, done8, busy8}, 33'd1);
        start8 = 1'b0;
        drain8();

        // Result hold with start low
        applyStimulus(8'd10, 8'd20, 1'b0, 33'd30);
        drain8();
        waitIdle8();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("hold_30", {24'd0, done8, carry8, sum8}, 33'd30);
        end

        // Asynchronous reset between E3 and E4 aborts the op
        waitIdle8();
        start8 = 1'b1;
        a8 = 8'd100;
        b8 = 8'd100;
        c8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", {23'd0, busy8, carry8, sum8}, 33'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        applyStimulus(8'd7, 8'd9, 1'b1, 33'd17);
        drain8();

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    waitIdle4();
                    start4 = 1'b1;
                    a4 = 4'(a);
                    b4 = 4'(b);
                    c4 = 1'(c);
                    q4.push_back(33'(a + b + c));
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = ~4'(a);
                    b4 = ~4'(b);
                    c4 = ~1'(c);
                end
            end
        end
        drain4();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add sequencer that shares a single `full_adder` instance across all bit positions of a WIDTH-bit addition. It latches two operands and a carry-in, then steps the one-bit full adder LSB-first, once per clock. It holds the running carry in a flop and assembles the sum in a shift register. A start/busy/done handshake lets a host issue one addition at a time without dedicating a WIDTH-bit ripple adder.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk_in  input  1  system clock, rising-edge active
- rst_in  input  1  reset, asynchronous, active-high
- start_in  input  1  request a new addition; sampled only in IDLE
- a_in  input  WIDTH  operand A; sampled on the accepting edge
- b_in  input  WIDTH  operand B; sampled on the accepting edge
- c_in  input  1  carry-in; sampled on the accepting edge
- sum_out  output  WIDTH  result sum; valid from done_out, held until the next result
- carry_out  output  1  result carry-out; same validity as sum_out
- busy_out  output  1  high while an addition is in progress (state RUN)
- done_out  output  1  one-cycle pulse marking the cycle a new result is first valid

## Operation

- Datapath: one `full_adder` instance (ports a_in, b_in, c_in, sum_out, carry_out).
  - Inputs: bit 0 of the A shift register, bit 0 of the B shift register, and the carry flop.
- Internal state:
  - A/B shift registers (WIDTH each), shifting right
  - sum shift register (WIDTH), shifting right, with the new bit entering at the MSB
  - carry flop
  - bit counter, sized $clog2(WIDTH)+1
  - result registers for sum_out and carry_out
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy_out=0.
  - If start_in=1: load the A/B shift registers with a_in/b_in, load the carry flop with c_in, clear the counter, go to RUN.
- RUN:
  - busy_out=1.
  - Each edge: sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}; A/B shift right one bit; carry flop <= fa_carry; counter +1.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
    - sum_out <= {fa_sum, sum_sr[WIDTH-1:1]}
    - carry_out <= fa_carry
    - go to DONE
- DONE:
  - done_out=1 and busy_out=0 for exactly one cycle.
  - Unconditionally go to IDLE.
- start_in is ignored in RUN and DONE. The host must hold or re-assert it in IDLE; no request is queued.
- a_in, b_in and c_in may change freely after the accepting edge; later changes have no effect on the operation in flight.
- Arithmetic: {carry_out, sum_out} = a_in + b_in + c_in, exact modulo 2^(WIDTH+1); no overflow flag.
- sum_out and carry_out update only on entry to DONE. They keep the previous result through IDLE and RUN and never show partial sums.
- Reset (any time, including mid-RUN):
  - The in-flight operation is aborted.
  - State goes to IDLE.
  - All registers and outputs are cleared: sum_out=0, carry_out=0, busy_out=0, done_out=0.
- Release of reset: the first accepting edge is the first rising edge with rst_in=0 and start_in=1.

## Timing

- Accepting edge E0: start_in=1 in IDLE. busy_out rises after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH-1.
- After E_WIDTH: done_out=1, busy_out=0, result valid.
- After E_(WIDTH+1): done_out=0, back in IDLE.
- Latency from the accepting edge to done_out: WIDTH edges.
- Minimum issue interval: WIDTH+2 cycles. The earliest next accept is E_(WIDTH+2), with start_in held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=8; a=3, b=5, c=0; start pulsed 1 cycle. Required:
  - busy_out high for exactly 8 cycles
  - done_out pulses once, 8 edges after accept
  - sum_out=8, carry_out=0
- a=255, b=1, c=0. Required: sum_out=0, carry_out=1. Then a=255, b=255, c=1. Required: sum_out=255, carry_out=1.
- start_in held high continuously with a=10, b=20, c=0; operands changed to a=1, b=1 mid-RUN. Required:
  - the first result is 30 (mid-RUN changes have no effect)
  - the next accept happens exactly at E10
  - the second result is 2
- Reset mid-operation: accept a=100, b=100, then assert rst_in asynchronously between E3 and E4. Required:
  - immediately (no clock edge needed): sum_out=0, carry_out=0, busy_out=0
  - no done_out pulse
  - after release, a=7, b=9, c=1 yields 17
- Result hold: after a result of 30, leave start_in low for 20 cycles. Required: sum_out stays 30, done_out stays 0.
- Exhaustive sweep at WIDTH=4 over all a, b, c (512 ops). Required: {carry_out, sum_out} == a+b+c each time.
